// File: rtl/blinker_pkg.sv
// Shared mode encodings and sizing helper for the multi-channel LED blinker.
package blinker_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One blinker channel: mode/half-period/burst registers and a half-period counter.
// Outputs are registered; a config write always restarts the counter and beats sync.
module blink_channel
  import blinker_pkg::*;
#(
  parameter int CTR_W      = 26,
  parameter int BURST_W    = 4,
  parameter int DEFAULT_HP = 25000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [1:0]         i_mode,
  input  logic [CTR_W-1:0]   i_hp,
  input  logic [BURST_W-1:0] i_burst,
  input  logic               i_sync,
  output logic               o_led,
  output logic               o_tick,
  output logic               o_busy
);

  logic [1:0]         mode_q, mode_d;
  logic [CTR_W-1:0]   hp_q, hp_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               led_q, led_d;
  logic               tick_q, tick_d;
  logic               term;

  // hp of 0 or 1 both mean "toggle every clock"
  assign term = (hp_q <= CTR_W'(1)) || (ctr_q == hp_q - CTR_W'(1));

  always_comb begin
    mode_d = mode_q;
    hp_d   = hp_q;
    ctr_d  = ctr_q;
    rem_d  = rem_q;
    led_d  = led_q;
    tick_d = 1'b0;
    if (i_we) begin
      ctr_d  = '0;
      hp_d   = i_hp;
      rem_d  = i_burst;
      mode_d = (i_mode == MODE_BURST && i_burst == '0) ? MODE_OFF : i_mode;
      led_d  = (i_mode == MODE_ON) || (i_mode == MODE_BURST && i_burst != '0);
    end else if (i_sync && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
      ctr_d = '0;
      led_d = (mode_q == MODE_BURST);
    end else begin
      case (mode_q)
        MODE_ON: begin
          ctr_d = '0;
          led_d = 1'b1;
        end
        MODE_BLINK: begin
          if (term) begin
            ctr_d  = '0;
            led_d  = ~led_q;
            tick_d = 1'b1;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
        MODE_BURST: begin
          if (!term) begin
            ctr_d = ctr_q + CTR_W'(1);
          end else begin
            ctr_d = '0;
            if (led_q) begin
              led_d  = 1'b0;
              tick_d = 1'b1;
            end else if (rem_q <= BURST_W'(1)) begin
              // last low phase done: channel parks in OFF, busy drops here
              mode_d = MODE_OFF;
              rem_d  = '0;
            end else begin
              rem_d  = rem_q - BURST_W'(1);
              led_d  = 1'b1;
              tick_d = 1'b1;
            end
          end
        end
        default: begin
          ctr_d = '0;
          led_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q <= MODE_BLINK;
      hp_q   <= CTR_W'(DEFAULT_HP);
      ctr_q  <= '0;
      rem_q  <= '0;
      led_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      hp_q   <= hp_d;
      ctr_q  <= ctr_d;
      rem_q  <= rem_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign o_led  = led_q;
  assign o_tick = tick_q;
  assign o_busy = (mode_q == MODE_BURST);

endmodule

// File: rtl/multi_chan_blinker.sv
// N-channel LED blinker: decodes config writes to per-channel strobes and fans out sync.
// Channel indices >= N_CH match no strobe, so such writes are dropped.
module multi_chan_blinker
  import blinker_pkg::*;
#(
  parameter int N_CH       = 5,
  parameter int CTR_W      = 26,
  parameter int BURST_W    = 4,
  parameter int DEFAULT_HP = 25000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cfg_we,
  input  logic [ch_w(N_CH)-1:0]   i_cfg_ch,
  input  logic [1:0]              i_cfg_mode,
  input  logic [CTR_W-1:0]        i_cfg_hp,
  input  logic [BURST_W-1:0]      i_cfg_burst,
  input  logic                    i_sync,
  output logic [N_CH-1:0]         o_led,
  output logic [N_CH-1:0]         o_tick,
  output logic [N_CH-1:0]         o_busy
);

  localparam int CH_W = ch_w(N_CH);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic we;
    assign we = i_cfg_we && (i_cfg_ch == CH_W'(k));

    blink_channel #(
      .CTR_W      (CTR_W),
      .BURST_W    (BURST_W),
      .DEFAULT_HP (DEFAULT_HP)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (we),
      .i_mode  (i_cfg_mode),
      .i_hp    (i_cfg_hp),
      .i_burst (i_cfg_burst),
      .i_sync  (i_sync),
      .o_led   (o_led[k]),
      .o_tick  (o_tick[k]),
      .o_busy  (o_busy[k])
    );
  end

endmodule

// File: tb/tb_multi_chan_blinker.sv
// Bench for multi_chan_blinker: a vector table for single-edge behaviour, then timed sequences;
// expectations go through a scoreboard queue and are compared on the falling edge.
module tb_multi_chan_blinker;
  import blinker_pkg::*;

  localparam int N_CH    = 5;
  localparam int CTR_W   = 26;
  localparam int BURST_W = 4;
  localparam int DEF_HP  = 20;
  localparam int CH_W    = ch_w(N_CH);

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_cfg_we;
  logic [CH_W-1:0]     i_cfg_ch;
  logic [1:0]          i_cfg_mode;
  logic [CTR_W-1:0]    i_cfg_hp;
  logic [BURST_W-1:0]  i_cfg_burst;
  logic                i_sync;
  logic [N_CH-1:0]     o_led, o_tick, o_busy;

  always #5 i_clk = ~i_clk;

  multi_chan_blinker #(
    .N_CH(N_CH), .CTR_W(CTR_W), .BURST_W(BURST_W), .DEFAULT_HP(DEF_HP)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
    .i_cfg_mode(i_cfg_mode), .i_cfg_hp(i_cfg_hp), .i_cfg_burst(i_cfg_burst),
    .i_sync(i_sync), .o_led(o_led), .o_tick(o_tick), .o_busy(o_busy)
  );

  typedef struct {
    logic [N_CH-1:0] led, tick, busy, mask;
  } exp_t;

  typedef struct {
    logic               rst, we;
    logic [CH_W-1:0]    ch;
    logic [1:0]         mode;
    logic [CTR_W-1:0]   hp;
    logic [BURST_W-1:0] burst;
    logic               sync;
    exp_t               e;
  } vec_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t none();
    exp_t e;
    e.led = '0; e.tick = '0; e.busy = '0; e.mask = '0;
    return e;
  endfunction

  function automatic exp_t chx(input exp_t e0, input int c, input bit led, input bit tick, input bit busy);
    exp_t e = e0;
    e.led[c] = led; e.tick[c] = tick; e.busy[c] = busy; e.mask[c] = 1'b1;
    return e;
  endfunction

  function automatic vec_t v(input logic rst, input logic we, input int ch, input logic [1:0] mode,
                             input int hp, input int burst, input logic sync,
                             input logic [N_CH-1:0] led, input logic [N_CH-1:0] tick,
                             input logic [N_CH-1:0] busy);
    vec_t r;
    r.rst = rst; r.we = we; r.ch = CH_W'(ch); r.mode = mode;
    r.hp = CTR_W'(hp); r.burst = BURST_W'(burst); r.sync = sync;
    r.e.led = led; r.e.tick = tick; r.e.busy = busy; r.e.mask = '1;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic we, input int ch, input logic [1:0] mode,
                       input int hp, input int burst, input logic sync);
    i_rst = rst; i_cfg_we = we; i_cfg_ch = CH_W'(ch); i_cfg_mode = mode;
    i_cfg_hp = CTR_W'(hp); i_cfg_burst = BURST_W'(burst); i_sync = sync;
  endtask

  task automatic check(input string name);
    exp_t e = sb_q.pop_front();
    n_vec++;
    if ((((o_led ^ e.led) | (o_tick ^ e.tick) | (o_busy ^ e.busy)) & e.mask) != '0) begin
      n_err++;
      $display("FAIL %s: got led=%b tick=%b busy=%b, want led=%b tick=%b busy=%b (mask %b)",
               name, o_led, o_tick, o_busy, e.led, e.tick, e.busy, e.mask);
    end
  endtask

  // Inputs must already be driven; one edge is taken, then inputs return to idle.
  task automatic step(input string name, input exp_t e);
    sb_q.push_back(e);
    @(posedge i_clk);
    @(negedge i_clk);
    check(name);
    drive(0, 0, 0, MODE_OFF, 0, 0, 0);
  endtask

  vec_t tbl[17];

  initial begin
    int ticks;
    exp_t e;

    tbl[0]  = v(1, 0, 0, MODE_OFF,   0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[1]  = v(1, 1, 0, MODE_ON,    3, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[2]  = v(0, 0, 0, MODE_OFF,   0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[3]  = v(0, 1, 4, MODE_OFF,   5, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[4]  = v(0, 1, 5, MODE_ON,    0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[5]  = v(0, 1, 7, MODE_ON,    0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[6]  = v(0, 1, 3, MODE_ON,    9, 0, 0, 5'b01000, 5'b00000, 5'b00000);
    tbl[7]  = v(0, 1, 2, MODE_BURST, 3, 0, 0, 5'b01000, 5'b00000, 5'b00000);
    tbl[8]  = v(0, 1, 1, MODE_BURST, 1, 1, 0, 5'b01010, 5'b00000, 5'b00010);
    tbl[9]  = v(0, 0, 0, MODE_OFF,   0, 0, 0, 5'b01000, 5'b00010, 5'b00010);
    tbl[10] = v(0, 0, 0, MODE_OFF,   0, 0, 0, 5'b01000, 5'b00000, 5'b00000);
    tbl[11] = v(0, 1, 0, MODE_BLINK, 0, 0, 0, 5'b01000, 5'b00000, 5'b00000);
    tbl[12] = v(0, 0, 0, MODE_OFF,   0, 0, 0, 5'b01001, 5'b00001, 5'b00000);
    tbl[13] = v(0, 0, 0, MODE_OFF,   0, 0, 0, 5'b01000, 5'b00001, 5'b00000);
    tbl[14] = v(0, 0, 0, MODE_OFF,   0, 0, 1, 5'b01000, 5'b00000, 5'b00000);
    tbl[15] = v(0, 0, 0, MODE_OFF,   0, 0, 0, 5'b01001, 5'b00001, 5'b00000);
    tbl[16] = v(0, 1, 0, MODE_OFF,   0, 0, 1, 5'b01000, 5'b00000, 5'b00000);

    drive(1, 0, 0, MODE_OFF, 0, 0, 0);
    @(negedge i_clk);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].we, int'(tbl[i].ch), tbl[i].mode,
            int'(tbl[i].hp), int'(tbl[i].burst), tbl[i].sync);
      step($sformatf("vec%0d", i), tbl[i].e);
    end

    // ch0 BLINK hp=4: period 8, tick on each toggle
    for (int n = 0; n <= 24; n++) begin
      if (n == 0) drive(0, 1, 0, MODE_BLINK, 4, 0, 0);
      step($sformatf("blink4_n%0d", n), chx(none(), 0, ((n / 4) % 2) == 1, n > 0 && n % 4 == 0, 0));
    end

    // ch1 BURST hp=2 x3: 1,1,0,0 repeated, busy 12 clocks, then OFF
    ticks = 0;
    for (int n = 0; n <= 16; n++) begin
      if (n == 0) drive(0, 1, 1, MODE_BURST, 2, 3, 0);
      step($sformatf("burst_n%0d", n),
           chx(none(), 1, n < 12 && ((n / 2) % 2) == 0, n > 0 && n < 12 && n % 2 == 0, n < 12));
      if (o_tick[1]) ticks++;
    end
    n_vec++;
    if (ticks != 5) begin
      n_err++;
      $display("FAIL burst_tick_count: got %0d, want 5", ticks);
    end

    // ch2 hp=10, rewritten to hp=3 at ctr=7, then rewritten again on its terminal count
    for (int n = 0; n <= 20; n++) begin
      bit led, tk;
      if (n == 0) drive(0, 1, 2, MODE_BLINK, 10, 0, 0);
      if (n == 8 || n == 17) drive(0, 1, 2, MODE_BLINK, 3, 0, 0);
      led = (n >= 11 && n <= 13) || n == 20;
      tk  = (n == 11 || n == 14 || n == 20);
      step($sformatf("hpchg_n%0d", n), chx(none(), 2, led, tk, 0));
    end

    // ch0 hp=4 and ch3 hp=6 out of phase, then sync aligns them
    for (int n = 0; n <= 31; n++) begin
      if (n == 0) drive(0, 1, 0, MODE_BLINK, 4, 0, 0);
      if (n == 1) drive(0, 1, 3, MODE_BLINK, 6, 0, 0);
      if (n == 7) drive(0, 0, 0, MODE_OFF, 0, 0, 1);
      if (n < 7) begin
        e = chx(none(), 0, ((n / 4) % 2) == 1, n > 0 && n % 4 == 0, 0);
        if (n >= 1) e = chx(e, 3, (((n - 1) / 6) % 2) == 1, n > 1 && (n - 1) % 6 == 0, 0);
      end else begin
        e = chx(none(), 0, (((n - 7) / 4) % 2) == 1, n > 7 && (n - 7) % 4 == 0, 0);
        e = chx(e, 3, (((n - 7) / 6) % 2) == 1, n > 7 && (n - 7) % 6 == 0, 0);
      end
      step($sformatf("sync_n%0d", n), e);
    end

    // ch1 burst hp=3 x2, sync in the low phase restarts the pulse, then reset mid-burst
    for (int n = 0; n <= 9; n++) begin
      if (n == 0) drive(0, 1, 1, MODE_BURST, 3, 2, 0);
      if (n == 5) drive(0, 0, 0, MODE_OFF, 0, 0, 1);
      if (n == 9) begin
        drive(1, 1, 1, MODE_ON, 2, 0, 1);
        e = none();
        e.mask = '1;
      end else begin
        e = chx(none(), 1, n < 3 || (n >= 5 && n <= 7), n == 3 || n == 8, 1);
      end
      step($sformatf("rstburst_n%0d", n), e);
    end
    for (int k = 1; k <= 21; k++) begin
      e.led  = (k >= 20) ? '1 : '0;
      e.tick = (k == 20) ? '1 : '0;
      e.busy = '0;
      e.mask = '1;
      step($sformatf("postrst_k%0d", k), e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
